// File: rtl/reg_mask_encoder_pkg.sv
// Shared definitions for the register-mask encoder and its priority encoder.
// Holds the FSM state enum, register-file geometry and emit-order selectors.
// No ports; imported by the encoder top and prio_enc16.
package reg_mask_pkg;

  localparam int NREGS = 16;
  localparam int IDX_W = 4;

  localparam int ORDER_ASC  = 0;
  localparam int ORDER_DESC = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_mask_encoder_if.sv
// Index stream from the mask encoder to the register-file port mux.
// Signals: idx_valid/idx/idx_last driven by the encoder, idx_ready by the consumer.
// master = encoder side, slave = consumer side.
interface reg_mask_encoder_if #(
  parameter int IDX_W = 4
) ();

  logic             idx_valid;
  logic [IDX_W-1:0] idx;
  logic             idx_ready;
  logic             idx_last;

  modport master (
    output idx_valid,
    output idx,
    output idx_last,
    input  idx_ready
  );

  modport slave (
    input  idx_valid,
    input  idx,
    input  idx_last,
    output idx_ready
  );

endinterface

// File: rtl/reg_mask_encoder_prio_enc16.sv
// Combinational 16->4 priority encoder; ORDER picks lowest (0) or highest (1) set bit.
// Ports: vec in, idx out (0 when vec is zero), onehot_or_zero out (vec has at most one bit set).
// Purely combinational, no state.
module prio_enc16 #(
  parameter int ORDER = reg_mask_pkg::ORDER_ASC
) (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        onehot_or_zero
);

  import reg_mask_pkg::*;

  always_comb begin
    idx = '0;
    if (ORDER == ORDER_ASC) begin
      // Scan downward so the last hit, i.e. the lowest set bit, wins.
      for (int i = NREGS - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for one-hot or empty vectors.
  assign onehot_or_zero = ((vec & (vec - 16'd1)) == 16'd0);

endmodule

// File: rtl/reg_mask_encoder.sv
// Serializes a 16-bit register mask into a stream of 4-bit register indices, one per handshake.
// Ports: clk, reset_n (sync, active-low), start/mask/abort control, idx_if index stream (master),
//        busy, done (one-cycle completion pulse), count (indices accepted in current/last sequence).
module reg_mask_encoder #(
  parameter int NREGS = 16,
  parameter int IDX_W = 4,
  parameter int ORDER = reg_mask_pkg::ORDER_ASC
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NREGS-1:0]    mask,
  input  logic                abort,
  reg_mask_encoder_if.master  idx_if,
  output logic                busy,
  output logic                done,
  output logic [IDX_W:0]      count
);

  import reg_mask_pkg::*;

  state_e           state_q, state_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_single;
  logic             emit;
  logic             hshake;

  prio_enc16 #(
    .ORDER (ORDER)
  ) u_prio_enc16 (
    .vec            (pending_q),
    .idx            (enc_idx),
    .onehot_or_zero (enc_single)
  );

  assign emit   = (state_q == ST_EMIT);
  assign hshake = emit && idx_if.idx_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        // abort in IDLE only serves to mask a coincident start.
        if (start && !abort) begin
          count_d = '0;
          if (mask != '0) begin
            pending_d = mask;
            state_d   = ST_EMIT;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end
      ST_EMIT: begin
        if (abort) begin
          pending_d = '0;
          state_d   = ST_IDLE;
        end else if (hshake) begin
          pending_d = pending_q & ~(NREGS'(1) << enc_idx);
          count_d   = count_q + (IDX_W + 1)'(1);
          if (enc_single) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pending_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        pending_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Outputs come from registered state; idx_ready never reaches them.
  assign idx_if.idx_valid = emit;
  assign idx_if.idx       = emit ? enc_idx : '0;
  assign idx_if.idx_last  = emit && enc_single;
  assign busy             = (state_q != ST_IDLE);
  // An abort landing on the DONE cycle cancels the completion pulse.
  assign done             = (state_q == ST_DONE) && !abort;
  assign count            = count_q;

endmodule

// File: doc/reg_mask_encoder.md
# reg_mask_encoder

Serializes a 16-bit register mask into a stream of 4-bit register indices, one per accepted handshake. It performs the inverse mapping of the Rdest-to-`regEnable` one-hot decode. The block sits between the control FSM and the register-file port mux and drives multi-register operations such as push/pop-multiple, context save/restore, and register dump. Each emitted index feeds the Rdest/Rsrc select path.

## Interface
Parameters:
- `NREGS`, 16: mask width and number of registers.
- `IDX_W`, 4: index width, equal to log2(`NREGS`).
- `ORDER`, 0: 0 emits lowest set bit first (ascending); 1 emits highest set bit first (descending).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request to begin a sequence; sampled only in IDLE.
- `mask`  in  16  set of registers to emit; sampled with `start`.
- `abort`  in  1  synchronous cancel of the current sequence.
- `idx_valid`  out  1  `idx` holds a valid register number.
- `idx`  out  4  current register index.
- `idx_ready`  in  1  consumer accepts `idx` this cycle.
- `idx_last`  out  1  current `idx` is the final index of the sequence.
- `busy`  out  1  high in EMIT and DONE.
- `done`  out  1  one-cycle pulse marking normal completion.
- `count`  out  5  number of indices accepted in the current or last sequence (0..16).

## Operation
- States: IDLE, EMIT, DONE. Encoded in a 2-bit enum.
- Internal registers: `pending[15:0]`, `count[4:0]`, state.
- IDLE:
  - `start`=1 and `mask`≠0: `pending`←`mask`, `count`←0, go to EMIT.
  - `start`=1 and `mask`=0: `count`←0, go to DONE. No index is emitted.
- EMIT:
  - `idx_valid`=1.
  - `idx` is the priority encode of `pending`: lowest set bit when `ORDER`=0, highest when `ORDER`=1.
  - `idx_last`=1 when `pending` has exactly one bit set.
  - On `idx_valid`&&`idx_ready`: clear bit `idx` in `pending` and increment `count`. If `idx_last`, go to DONE.
  - While `idx_ready`=0, `idx`, `idx_valid`, and `idx_last` hold stable.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `count` retains its final value until the next `start`.
- `start` is ignored outside IDLE.
- `abort`=1 in EMIT or DONE: go to IDLE next edge, clear `pending`, hold `count`, and do not pulse `done`. `abort` has priority over a handshake in the same cycle; that handshake is not counted. `abort` in IDLE is a no-op, and it has priority over `start`.
- `idx_ready` is ignored when `idx_valid`=0.
- All outputs are decoded from registered state plus `pending`. There is no combinational path from `idx_ready` to `idx_valid` or `idx`.

## Timing
- Reset values (the edge on which `reset_n`=0): state=IDLE, `pending`=0, `count`=0, `idx_valid`=0, `idx`=0, `idx_last`=0, `busy`=0, `done`=0.
- Reset asserted mid-sequence has the same effect as reset. No `done` pulse.
- `start` at edge N: `idx_valid`=1 during cycle N+1, with the first index present.
- Throughput is one index per cycle while `idx_ready`=1. A sequence with k set bits and `idx_ready` held high takes start → k EMIT cycles → 1 DONE cycle.
- `mask`=0 case: `done` is high in cycle N+1.
- `done` falls and `busy` falls in the same cycle. A new `start` is accepted on the first IDLE cycle.
- `count` updates on the handshake edge. It reads 16 after a full mask.
- When `idx_valid`=0, `idx` and `idx_last` are 0.

## Structure
- Shared package `reg_mask_pkg` holds:
  - the state enum (IDLE/EMIT/DONE),
  - `NREGS`=16 and `IDX_W`=4,
  - `ORDER_ASC`=0 and `ORDER_DESC`=1.
- Sub-module `prio_enc16`: combinational 16→4 priority encoder with an `ORDER` parameter and a `onehot_or_zero` flag output, which drives `idx_last`. It is reusable by the interrupt/flag logic.
- The top module contains the FSM, the `pending` register, and the counter.

## Test plan
- Reset, then `mask`=16'h8421, `ORDER`=0, `idx_ready`=1 → `idx` sequence 0,5,10,15 on consecutive cycles. `idx_last` is high only on 15, followed by a `done` pulse and `count`=4.
- Same mask with `ORDER`=1 → `idx` sequence 15,10,5,0.
- `mask`=16'hFFFF with `idx_ready` toggling 1,0,1,0… → 16 indices 0..15. `idx` is stable across every stall cycle, and `count`=16.
- `mask`=0 with `start` → no `idx_valid`, `done` high in the cycle after `start`, `count`=0.
- `mask`=16'h00F0, `abort` asserted together with the second handshake (`idx`=5) → IDLE next cycle, no `done`, `count`=1. A `start` pulsed during EMIT is ignored.
- Drop `reset_n` in the middle of a `mask`=16'h0F0F sequence → all outputs zero on the next edge, and a subsequent `start` begins cleanly at `idx`=0.
